// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: synchronizes and debounces board event inputs, latches
// rising edges as pending, and presents one interrupt at a time to the
// OTTER MCU through an assert / acknowledge / end-of-interrupt handshake.
// A four-register MMIO window (PENDING, MASK, CAUSE, EOI) configures it.
module otter_intr_ctrl #(
  parameter int NUM_SRC         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] SRC_IN,
  output logic               INTR,
  input  logic               INTR_ACK,
  input  logic [1:0]         IO_ADDR,
  input  logic               IO_WE,
  input  logic [7:0]         IO_WDATA,
  output logic [7:0]         IO_RDATA
);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_CAUSE   = 2'd2;
  localparam logic [1:0] ADDR_EOI     = 2'd3;

  // Counter value reached on the last of DEBOUNCE_CYCLES consecutive mismatches.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Isolate the lowest set bit: source 0 has the highest priority.
  function automatic logic [NUM_SRC-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
    return v & (~v + NUM_SRC'(1));
  endfunction

  // Convert a one-hot source vector to its 3-bit source id.
  function automatic logic [2:0] encode_id(input logic [NUM_SRC-1:0] onehot);
    logic [2:0] id;
    id = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (onehot[i]) id = 3'(i);
    end
    return id;
  endfunction

  // Input path state
  logic [NUM_SRC-1:0] sync_p0;
  logic [NUM_SRC-1:0] sync_p1;
  logic [NUM_SRC-1:0] filt;
  logic [NUM_SRC-1:0] filt_prev;
  logic [CNT_W-1:0]   db_cnt [NUM_SRC];
  logic [NUM_SRC-1:0] rise;

  // Registers and control
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_nx;
  logic [NUM_SRC-1:0] mask;
  logic               cause_vld;
  logic [2:0]         cause_id;
  state_t             state;
  state_t             state_nx;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] win_oh;
  logic [2:0]         win_id;
  logic               ack_take;
  logic               eoi_take;

  logic               wr_pending;
  logic               wr_mask;
  logic               wr_eoi;

  // Only the low NUM_SRC write-data bits have register state behind them.
  logic               unused_wdata;
  assign unused_wdata = &{1'b0, IO_WDATA};

  assign wr_pending = IO_WE && (IO_ADDR == ADDR_PENDING);
  assign wr_mask    = IO_WE && (IO_ADDR == ADDR_MASK);
  assign wr_eoi     = IO_WE && (IO_ADDR == ADDR_EOI);

  // --- stage p0/p1: two-flop synchronizer for the asynchronous requests ---
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= SRC_IN;
      sync_p1 <= sync_p0;
    end
  end

  // --- debounce: filtered level follows sync_p1 after DEBOUNCE_CYCLES stable mismatches ---
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt <= '0;
      for (int i = 0; i < NUM_SRC; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sync_p1[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // --- edge capture: remember last filtered level to detect 0->1 transitions ---
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_prev <= '0;
    end else begin
      filt_prev <= filt;
    end
  end

  assign rise = filt & ~filt_prev;

  // Arbitration is continuous so the winner is whatever is eligible at the ACK edge.
  assign eligible = pending & mask;
  assign win_oh   = lowest_set(eligible);
  assign win_id   = encode_id(win_oh);

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state; ACK and EOI are only honoured in the state that expects them.
  always_comb begin
    state_nx = state;
    ack_take = 1'b0;
    eoi_take = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|eligible) state_nx = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!(|eligible)) begin
          state_nx = ST_IDLE;
        end else if (INTR_ACK) begin
          state_nx = ST_SERVICE;
          ack_take = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi) begin
          state_nx = ST_IDLE;
          eoi_take = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign INTR = (state == ST_ASSERT);

  // Pending next value: clears first, hardware set last so a set beats a same-cycle W1C.
  always_comb begin
    pending_nx = pending;
    if (wr_pending) pending_nx = pending_nx & ~IO_WDATA[NUM_SRC-1:0];
    if (ack_take)   pending_nx = pending_nx & ~win_oh;
    pending_nx = pending_nx | rise;
  end

  // Pending and mask registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= pending_nx;
      if (wr_mask) mask <= IO_WDATA[NUM_SRC-1:0];
    end
  end

  // Cause register: valid set on acknowledge, cleared on EOI; id is retained.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cause_vld <= 1'b0;
      cause_id  <= '0;
    end else if (ack_take) begin
      cause_vld <= 1'b1;
      cause_id  <= win_id;
    end else if (eoi_take) begin
      cause_vld <= 1'b0;
    end
  end

  // Combinational MMIO read mux; unused upper bits read as zero.
  always_comb begin
    IO_RDATA = '0;
    case (IO_ADDR)
      ADDR_PENDING: IO_RDATA[NUM_SRC-1:0] = pending;
      ADDR_MASK:    IO_RDATA[NUM_SRC-1:0] = mask;
      ADDR_CAUSE:   IO_RDATA = {cause_vld, 4'b0000, cause_id};
      default:      IO_RDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb_otter_intr_ctrl: directed scenarios plus randomized traffic, every cycle
// checked against a behavioural model of the interrupt controller.
module tb_otter_intr_ctrl;

  localparam int NS = 4;
  localparam int DB = 4;

  localparam int S_IDLE    = 0;
  localparam int S_ASSERT  = 1;
  localparam int S_SERVICE = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [NS-1:0] SRC_IN = '0;
  logic          INTR;
  logic          INTR_ACK = 1'b0;
  logic [1:0]    IO_ADDR = '0;
  logic          IO_WE = 1'b0;
  logic [7:0]    IO_WDATA = '0;
  logic [7:0]    IO_RDATA;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  otter_intr_ctrl #(
    .NUM_SRC(NS),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(16)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .SRC_IN(SRC_IN),
    .INTR(INTR),
    .INTR_ACK(INTR_ACK),
    .IO_ADDR(IO_ADDR),
    .IO_WE(IO_WE),
    .IO_WDATA(IO_WDATA),
    .IO_RDATA(IO_RDATA)
  );

  // Reference model state
  logic [NS-1:0] m_pend, m_mask, m_d1, m_s, m_filt, m_setq;
  logic          m_cv;
  logic [2:0]    m_cid;
  int            m_state;
  logic [31:0]   m_hist [NS];
  int            m_n [NS];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_d1 = '0; m_s = '0; m_filt = '0; m_setq = '0;
    m_cv = 1'b0; m_cid = '0; m_state = S_IDLE;
    for (int i = 0; i < NS; i++) begin
      m_hist[i] = '0;
      m_n[i] = 0;
    end
  endtask

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {4'b0000, m_pend};
      2'd1:    return {4'b0000, m_mask};
      2'd2:    return {m_cv, 4'b0000, m_cid};
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge of the model, using the inputs present before the edge.
  task automatic model_step();
    logic [NS-1:0] elig, np, nf, nset;
    int win;
    bit ok;
    elig = m_pend & m_mask;
    win = -1;
    for (int i = 0; i < NS; i++) if (elig[i] && win < 0) win = i;
    np = m_pend;
    if (IO_WE && IO_ADDR == 2'd0) np = np & ~IO_WDATA[NS-1:0];
    case (m_state)
      S_IDLE: if (win >= 0) m_state = S_ASSERT;
      S_ASSERT: begin
        if (win < 0) m_state = S_IDLE;
        else if (INTR_ACK) begin
          m_state = S_SERVICE;
          np[win] = 1'b0;
          m_cv = 1'b1;
          m_cid = 3'(win);
        end
      end
      default: if (IO_WE && IO_ADDR == 2'd3) begin
        m_state = S_IDLE;
        m_cv = 1'b0;
      end
    endcase
    np = np | m_setq;
    if (IO_WE && IO_ADDR == 2'd1) m_mask = IO_WDATA[NS-1:0];
    m_pend = np;
    // Filtered level flips once the last DB synchronized samples all disagree with it.
    nf = m_filt;
    nset = '0;
    for (int i = 0; i < NS; i++) begin
      m_hist[i] = {m_hist[i][30:0], m_s[i]};
      if (m_n[i] < 32) m_n[i]++;
      ok = (m_n[i] >= DB);
      for (int j = 0; j < DB; j++) if (m_hist[i][j] == m_filt[i]) ok = 1'b0;
      if (ok) begin
        nf[i] = ~m_filt[i];
        nset[i] = nf[i];
      end
    end
    m_setq = nset;
    m_filt = nf;
    m_s = m_d1;
    m_d1 = SRC_IN;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST_N) model_step();
    else model_reset();
    @(negedge CLK);
    chk("intr", 8'(INTR), 8'(m_state == S_ASSERT));
    chk("rdata", IO_RDATA, m_read(IO_ADDR));
  endtask

  task automatic read_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    IO_WE = 1'b0;
    IO_ADDR = a;
    #1;
    chk(tag, IO_RDATA, exp);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    IO_WE = 1'b1;
    IO_ADDR = a;
    IO_WDATA = d;
    tick();
    IO_WE = 1'b0;
  endtask

  task automatic ack();
    INTR_ACK = 1'b1;
    tick();
    INTR_ACK = 1'b0;
  endtask

  task automatic do_reset();
    SRC_IN = '0;
    IO_WE = 1'b0;
    INTR_ACK = 1'b0;
    RST_N = 1'b0;
    model_reset();
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    int k;
    model_reset();
    @(negedge CLK);

    // Reset with all sources requesting
    SRC_IN = 4'hF;
    RST_N = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (5) tick();
    chk("rst_intr", 8'(INTR), 8'h00);
    read_reg("rst_pending", 2'd0, 8'h00);
    read_reg("rst_mask", 2'd1, 8'h00);
    read_reg("rst_cause", 2'd2, 8'h00);
    do_reset();

    // Debounce latency and glitch rejection
    write_reg(2'd1, 8'h01);
    IO_ADDR = 2'd0;
    SRC_IN[0] = 1'b1;
    repeat (6) tick();
    chk("lat_pend_e6", IO_RDATA, 8'h00);
    tick();
    chk("lat_pend_e7", IO_RDATA, 8'h01);
    chk("lat_intr_e7", 8'(INTR), 8'h00);
    tick();
    chk("lat_intr_e8", 8'(INTR), 8'h01);
    ack();
    read_reg("lat_cause", 2'd2, 8'h80);
    write_reg(2'd3, 8'h00);
    SRC_IN[1] = 1'b1;
    repeat (3) tick();
    SRC_IN[1] = 1'b0;
    repeat (12) tick();
    read_reg("glitch_pend", 2'd0, 8'h00);
    SRC_IN[0] = 1'b0;
    repeat (10) tick();

    // Priority and full handshake
    do_reset();
    write_reg(2'd1, 8'h0F);
    SRC_IN = 4'b1010;
    repeat (8) tick();
    chk("pri_intr", 8'(INTR), 8'h01);
    read_reg("pri_pend", 2'd0, 8'h0A);
    ack();
    chk("pri_intr_ack", 8'(INTR), 8'h00);
    read_reg("pri_cause1", 2'd2, 8'h81);
    read_reg("pri_pend1", 2'd0, 8'h08);
    write_reg(2'd3, 8'h00);
    read_reg("pri_cause_eoi", 2'd2, 8'h01);
    tick();
    chk("pri_intr_again", 8'(INTR), 8'h01);
    ack();
    read_reg("pri_cause2", 2'd2, 8'h83);
    read_reg("pri_pend2", 2'd0, 8'h00);
    write_reg(2'd3, 8'h00);

    // Higher priority arriving while asserted
    do_reset();
    write_reg(2'd1, 8'h0F);
    SRC_IN = 4'b0100;
    repeat (8) tick();
    chk("late_intr", 8'(INTR), 8'h01);
    SRC_IN = 4'b0101;
    repeat (8) tick();
    read_reg("late_pend", 2'd0, 8'h05);
    ack();
    read_reg("late_cause", 2'd2, 8'h80);
    read_reg("late_pend_ack", 2'd0, 8'h04);
    write_reg(2'd3, 8'h00);
    tick();
    ack();
    read_reg("late_cause2", 2'd2, 8'h82);
    write_reg(2'd3, 8'h00);

    // Masking
    do_reset();
    SRC_IN = 4'b0010;
    repeat (10) tick();
    read_reg("mask_pend", 2'd0, 8'h02);
    chk("mask_intr_off", 8'(INTR), 8'h00);
    write_reg(2'd1, 8'h02);
    tick();
    chk("mask_intr_on", 8'(INTR), 8'h01);
    write_reg(2'd1, 8'h00);
    tick();
    chk("mask_intr_drop", 8'(INTR), 8'h00);
    read_reg("mask_pend_kept", 2'd0, 8'h02);

    // Asynchronous reset during service
    write_reg(2'd1, 8'h02);
    tick();
    ack();
    SRC_IN = '0;
    RST_N = 1'b0;
    model_reset();
    read_reg("arst_pend", 2'd0, 8'h00);
    chk("arst_intr", 8'(INTR), 8'h00);
    read_reg("arst_mask", 2'd1, 8'h00);
    read_reg("arst_cause", 2'd2, 8'h00);
    repeat (2) tick();
    RST_N = 1'b1;
    tick();

    // Hardware set racing a W1C, then ACK racing a W1C of the winner
    write_reg(2'd1, 8'h01);
    SRC_IN[0] = 1'b1;
    repeat (6) tick();
    IO_WE = 1'b1;
    IO_ADDR = 2'd0;
    IO_WDATA = 8'h01;
    tick();
    IO_WE = 1'b0;
    read_reg("race_pend", 2'd0, 8'h01);
    tick();
    IO_WE = 1'b1;
    IO_ADDR = 2'd0;
    IO_WDATA = 8'h01;
    INTR_ACK = 1'b1;
    tick();
    IO_WE = 1'b0;
    INTR_ACK = 1'b0;
    read_reg("ackw1c_cause", 2'd2, 8'h80);
    read_reg("ackw1c_pend", 2'd0, 8'h00);
    write_reg(2'd3, 8'h00);
    ack();
    read_reg("idle_ack_cause", 2'd2, 8'h00);

    // Randomized traffic against the model
    do_reset();
    write_reg(2'd1, 8'($urandom_range(0, 15)));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        k = int'($urandom_range(0, NS - 1));
        SRC_IN[k] = ~SRC_IN[k];
      end
      INTR_ACK = ($urandom_range(0, 5) == 0);
      IO_WE = ($urandom_range(0, 7) == 0);
      IO_ADDR = 2'($urandom_range(0, 3));
      IO_WDATA = 8'($urandom);
      tick();
    end
    IO_WE = 1'b0;
    INTR_ACK = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
